// File: rtl/systolic_mm_nxn.sv
// NxN output-stationary systolic multiplier C = A x B; o_done at 3N-1 cycles after start with contiguous beats.
// Backpressure: o_ready high only in LOAD; gaps in i_valid freeze the whole array, DRAIN ignores i_valid.
module systolic_mm_nxn #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N) + 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_valid,
    input  logic [N*DATA_WIDTH-1:0]    i_a_col,
    input  logic [N*DATA_WIDTH-1:0]    i_b_row,
    output logic                       o_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [N*N*ACC_WIDTH-1:0]   o_c
);
    localparam int CNT_W = $clog2(2*N+1) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CNT_W-1:0]        drain_cnt;
    logic                    step;
    logic                    clear;

    logic [DATA_WIDTH-1:0]   a_edge  [N];
    logic [DATA_WIDTH-1:0]   b_edge  [N];
    logic [DATA_WIDTH-1:0]   a_west  [N];
    logic [DATA_WIDTH-1:0]   b_north [N];
    logic [DATA_WIDTH-1:0]   a_skew  [N][N];
    logic [DATA_WIDTH-1:0]   b_skew  [N][N];
    logic [DATA_WIDTH-1:0]   a_in    [N][N];
    logic [DATA_WIDTH-1:0]   b_in    [N][N];
    logic [DATA_WIDTH-1:0]   a_pass  [N][N];
    logic [DATA_WIDTH-1:0]   b_pass  [N][N];
    logic [2*DATA_WIDTH-1:0] prod    [N][N];
    logic [ACC_WIDTH-1:0]    acc     [N][N];

    assign step  = (state == LOAD && i_valid) || (state == DRAIN);
    assign clear = (state == IDLE) && i_start;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            o_ready   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= LOAD;
                        o_ready   <= 1'b1;
                        o_busy    <= 1'b1;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (i_valid) begin
                        if (beat_cnt == CNT_W'(N-1)) begin
                            beat_cnt <= '0;
                            o_ready  <= 1'b0;
                            if (N == 1) begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end else begin
                                state  <= DRAIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // 2N-2 flush steps carry the last operand to PE(N-1,N-1)
                    if (drain_cnt == CNT_W'(2*N-3)) begin
                        drain_cnt <= '0;
                        state     <= DONE;
                        o_done    <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign a_edge[i] = (state == LOAD) ? i_a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_edge[i] = (state == LOAD) ? i_b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (i == 0) begin : g_noskew
            assign a_west[i]  = a_edge[i];
            assign b_north[i] = b_edge[i];
        end else begin : g_skew
            assign a_west[i]  = a_skew[i][i-1];
            assign b_north[i] = b_skew[i][i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_west[i];
            end else begin : g_a_pass
                assign a_in[i][j] = a_pass[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b_north[j];
            end else begin : g_b_pass
                assign b_in[i][j] = b_pass[i-1][j];
            end
            assign prod[i][j] = {{DATA_WIDTH{1'b0}}, a_in[i][j]} * {{DATA_WIDTH{1'b0}}, b_in[i][j]};
            assign o_c[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] = acc[i][j];
        end
    end

    // Only the first i stages of skew row i feed the array; deeper stages are don't-care.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_skew[i][j] <= '0;
                    b_skew[i][j] <= '0;
                    a_pass[i][j] <= '0;
                    b_pass[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_skew[i][j] <= '0;
                    b_skew[i][j] <= '0;
                    a_pass[i][j] <= '0;
                    b_pass[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else if (step) begin
            for (int i = 0; i < N; i++) begin
                a_skew[i][0] <= a_edge[i];
                b_skew[i][0] <= b_edge[i];
                for (int s = 1; s < N; s++) begin
                    a_skew[i][s] <= a_skew[i][s-1];
                    b_skew[i][s] <= b_skew[i][s-1];
                end
                for (int j = 0; j < N; j++) begin
                    a_pass[i][j] <= a_in[i][j];
                    b_pass[i][j] <= b_in[i][j];
                    acc[i][j]    <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Bench for systolic_mm_nxn: N=1, N=3 and N=4 instances on a shared clock, table-driven runs
// checked against a plain matrix-product reference and the start-to-done cycle count.
module tb_systolic_mm_nxn;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start1, start3, start4;
    logic         valid;
    logic [31:0]  a_bus, b_bus;

    logic         ready1, busy1, done1;
    logic         ready3, busy3, done3;
    logic         ready4, busy4, done4;
    logic [16:0]  c1;
    logic [170:0] c3;
    logic [303:0] c4;

    int           total = 0;
    int           bad   = 0;
    int           sel_n = 3;
    logic         cur_ready, cur_busy, cur_done;
    logic [303:0] cur_c;

    always #5 clk = ~clk;

    systolic_mm_nxn #(.N(1), .DATA_WIDTH(8)) u_n1 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start1), .i_valid(valid),
        .i_a_col(a_bus[7:0]), .i_b_row(b_bus[7:0]),
        .o_ready(ready1), .o_busy(busy1), .o_done(done1), .o_c(c1)
    );

    systolic_mm_nxn #(.N(3), .DATA_WIDTH(8)) u_n3 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start3), .i_valid(valid),
        .i_a_col(a_bus[23:0]), .i_b_row(b_bus[23:0]),
        .o_ready(ready3), .o_busy(busy3), .o_done(done3), .o_c(c3)
    );

    systolic_mm_nxn #(.N(4), .DATA_WIDTH(8)) u_n4 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start4), .i_valid(valid),
        .i_a_col(a_bus), .i_b_row(b_bus),
        .o_ready(ready4), .o_busy(busy4), .o_done(done4), .o_c(c4)
    );

    always_comb begin
        cur_ready = 1'b0;
        cur_busy  = 1'b0;
        cur_done  = 1'b0;
        cur_c     = '0;
        case (sel_n)
            1: begin cur_ready = ready1; cur_busy = busy1; cur_done = done1; cur_c[16:0]  = c1; end
            3: begin cur_ready = ready3; cur_busy = busy3; cur_done = done3; cur_c[170:0] = c3; end
            4: begin cur_ready = ready4; cur_busy = busy4; cur_done = done4; cur_c        = c4; end
            default: ;
        endcase
    end

    // Operands are stored row-major in a 4x4 byte grid regardless of n; c uses the DUT's o_c layout.
    typedef struct packed {
        int           n;
        int           gap_beat;
        int           gap_len;
        int           noise;
        int           exp_done;
        logic [127:0] a;
        logic [127:0] b;
        logic [303:0] c;
    } vec_t;

    vec_t tab[9];

    function automatic logic [303:0] put_c(input logic [303:0] c, input int n, input int i,
                                           input int j, input int val);
        logic [303:0] r;
        r = c;
        if (n == 1) r[16:0] = 17'(val);
        else        r[(i*n+j)*19 +: 19] = 19'(val);
        return r;
    endfunction

    function automatic logic [303:0] model(input int n, input logic [127:0] a, input logic [127:0] b);
        logic [303:0] r;
        int           s, x, y;
        r = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    x = int'(a[(i*4+k)*8 +: 8]);
                    y = int'(b[(k*4+j)*8 +: 8]);
                    s = s + x * y;
                end
                r = put_c(r, n, i, j, s);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [303:0] act, input logic [303:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_start(input int n, input logic val);
        case (n)
            1: start1 = val;
            3: start3 = val;
            4: start4 = val;
            default: ;
        endcase
    endtask

    task automatic drive_beat(input vec_t v, input int k);
        for (int i = 0; i < v.n; i++) begin
            a_bus[i*8 +: 8] = v.a[(i*4+k)*8 +: 8];
            b_bus[i*8 +: 8] = v.b[(k*4+i)*8 +: 8];
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc, beat, gaps, done_at, extra;
        bit rdy_chk;
        sel_n = v.n;
        @(negedge clk);
        valid = 1'b0;
        set_start(v.n, 1'b1);
        cyc = 0;
        @(negedge clk);
        set_start(v.n, 1'b0);
        cyc = 1;
        chk({nm, " ready_in_load"}, 304'(cur_ready), 304'(1));
        chk({nm, " busy_in_load"}, 304'(cur_busy), 304'(1));
        beat = 0; gaps = v.gap_len; done_at = -1; rdy_chk = 0;
        while (cyc <= 60) begin
            if (cur_done) begin
                done_at = cyc;
                break;
            end
            if (beat == v.n && !rdy_chk) begin
                chk({nm, " ready_after_load"}, 304'(cur_ready), 304'(0));
                chk({nm, " busy_in_drain"}, 304'(cur_busy), 304'(1));
                rdy_chk = 1;
            end
            valid = 1'b0;
            a_bus = $urandom;
            b_bus = $urandom;
            if (beat < v.n) begin
                if (beat == v.gap_beat && gaps > 0) begin
                    gaps--;
                end else begin
                    valid = 1'b1;
                    drive_beat(v, beat);
                    beat++;
                end
            end else begin
                valid = (v.noise != 0);
            end
            set_start(v.n, v.noise != 0);
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done_cycle"}, 304'(done_at), 304'(v.exp_done));
        chk({nm, " c_at_done"}, cur_c, v.c);
        valid = (v.noise != 0);
        set_start(v.n, v.noise != 0);
        @(negedge clk);
        set_start(v.n, 1'b0);
        chk({nm, " idle_busy"}, 304'(cur_busy), 304'(0));
        chk({nm, " idle_done"}, 304'(cur_done), 304'(0));
        chk({nm, " idle_ready"}, 304'(cur_ready), 304'(0));
        extra = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (cur_done) extra++;
        end
        chk({nm, " no_extra_done"}, 304'(extra), 304'(0));
        chk({nm, " c_stable"}, cur_c, v.c);
        valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   gapc[9];
        int   ndone;
        string nm;

        gapc = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

        // identity
        v = '0; v.n = 3; v.gap_beat = -1; v.exp_done = 8;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) begin
                v.a[(i*4+k)*8 +: 8] = 8'(3*i+k+1);
                v.b[(i*4+k)*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
                v.c = put_c(v.c, 3, i, k, 3*i+k+1);
            end
        tab[0] = v;
        // identity with stray start/valid in LOAD, DRAIN, DONE and IDLE
        v.noise = 1;
        tab[1] = v;
        // saturated operands
        v = '0; v.n = 3; v.gap_beat = -1; v.exp_done = 8;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) begin
                v.a[(i*4+k)*8 +: 8] = 8'd255;
                v.b[(i*4+k)*8 +: 8] = 8'd255;
                v.c = put_c(v.c, 3, i, k, 195075);
            end
        tab[2] = v;
        // two idle cycles before the third beat
        v = '0; v.n = 3; v.gap_beat = 2; v.gap_len = 2; v.exp_done = 10;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) begin
                v.a[(i*4+k)*8 +: 8] = 8'(3*i+k+1);
                v.b[(i*4+k)*8 +: 8] = 8'(9-3*i-k);
                v.c = put_c(v.c, 3, i, k, gapc[i*3+k]);
            end
        tab[3] = v;
        // N=1 back-to-back
        v = '0; v.n = 1; v.gap_beat = -1; v.exp_done = 2;
        v.a[7:0] = 8'd7; v.b[7:0] = 8'd6; v.c = put_c(v.c, 1, 0, 0, 42);
        tab[4] = v;
        v.a[7:0] = 8'd3; v.b[7:0] = 8'd5; v.c = put_c(v.c, 1, 0, 0, 15);
        tab[5] = v;
        // N=4 random, second one with a random gap
        for (int r = 6; r < 8; r++) begin
            v = '0; v.n = 4; v.gap_beat = -1; v.exp_done = 11;
            for (int x = 0; x < 16; x++) begin
                v.a[x*8 +: 8] = 8'($urandom_range(0, 255));
                v.b[x*8 +: 8] = 8'($urandom_range(0, 255));
            end
            if (r == 7) begin
                v.gap_beat = $urandom_range(1, 3);
                v.gap_len  = $urandom_range(1, 3);
                v.exp_done = 11 + v.gap_len;
            end
            v.c = model(4, v.a, v.b);
            tab[r] = v;
        end
        // N=3 random
        v = '0; v.n = 3; v.gap_beat = -1; v.exp_done = 8;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) begin
                v.a[(i*4+k)*8 +: 8] = 8'($urandom_range(0, 255));
                v.b[(i*4+k)*8 +: 8] = 8'($urandom_range(0, 255));
            end
        v.c = model(3, v.a, v.b);
        tab[8] = v;

        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; start4 = 1'b0;
        valid = 1'b0; a_bus = '0; b_bus = '0;
        #1;
        chk("reset ready/busy/done n3", 304'({ready3, busy3, done3}), 304'(0));
        chk("reset ready/busy/done n1n4", 304'({ready1, busy1, done1, ready4, busy4, done4}), 304'(0));
        chk("reset c n3", 304'(c3), 304'(0));
        chk("reset c n4", c4, 304'(0));
        chk("reset c n1", 304'(c1), 304'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 9; r++) begin
            nm = $sformatf("vec%0d_n%0d", r, tab[r].n);
            run_vec(tab[r], nm);
        end

        // abort mid-LOAD: outputs clear at once and no done follows
        sel_n = 3;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        valid = 1'b1;
        drive_beat(tab[0], 0);
        @(negedge clk);
        drive_beat(tab[0], 1);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset ready/busy/done", 304'({ready3, busy3, done3}), 304'(0));
        chk("midreset c", 304'(c3), 304'(0));
        ndone = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (done3) ndone++;
            if (t == 4) rst_n = 1'b1;
        end
        chk("midreset no_done", 304'(ndone), 304'(0));
        run_vec(tab[0], "after_reset_identity");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_mm_nxn.md
Name: systolic_mm_nxn

Overview:
- Parametrised NxN output-stationary systolic matrix multiplier computing C = A x B for unsigned operands.
- Successor to the fixed 3x3 PE grid. Adds a generic N, internal input skewing, and a parametrised accumulator width.
- Adds a start/valid/ready/done control FSM that stalls the whole array on input gaps.
- Sits between the operand streaming buffers and the result writeback logic.

Parameters:
- N, 3, array dimension; matrices are NxN; N >= 1.
- DATA_WIDTH, 8, operand width in bits, unsigned.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N)+1, accumulator and result width; overflow is impossible for N products.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_valid  in  1  current beat (A column k, B row k) is valid.
- i_a_col  in  N*DATA_WIDTH  A[i][k] at slice [i*DATA_WIDTH +: DATA_WIDTH].
- i_b_row  in  N*DATA_WIDTH  B[k][j] at slice [j*DATA_WIDTH +: DATA_WIDTH].
- o_ready  out  1  array accepts a beat; high only in LOAD.
- o_busy  out  1  high in LOAD, DRAIN and DONE.
- o_done  out  1  one-cycle pulse; o_c is complete.
- o_c  out  N*N*ACC_WIDTH  C[i][j] at slice [(i*N+j)*ACC_WIDTH +: ACC_WIDTH].

Behaviour:
- Reset: async assert while i_rst=0 clears everything immediately. State=IDLE, o_ready=0, o_busy=0, o_done=0, o_c=0, and all skew, pass-through and beat/drain counters are 0.
- Reset mid-operation aborts the computation; no o_done follows.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - i_start=1 clears all accumulators and skew/pass registers and moves to LOAD next cycle.
  - Otherwise o_c holds the last result.
- LOAD:
  - o_ready=1. A beat fires when i_valid && o_ready. The beat counter counts 0..N-1.
  - The array advances (step enable) only on fire cycles. With i_valid=0 all PE, skew and pass registers hold, so gaps are legal.
  - On the Nth fire: go to DRAIN, or to DONE if N=1.
- DRAIN:
  - Array advances every cycle with zeros injected at the A and B edges.
  - Lasts exactly 2N-2 cycles (drain counter), then goes to DONE.
  - i_valid is ignored.
- DONE:
  - o_done=1 for one cycle, then IDLE.
  - i_start in DONE is ignored.
- i_start outside IDLE is ignored; there is no queueing.
- Skew: A row i passes through i step-enabled registers before PE(i,0). B column j passes through j step-enabled registers before PE(0,j).
- PE(i,j) on step enable:
  - acc <= acc + a_in*b_in, with the full-width product zero-extended to ACC_WIDTH.
  - a passes right and b passes down, each through one register.
- Element k reaches PE(i,j) at step k+i+j. The last product arrives at step 3N-3, and o_c is final in the cycle o_done=1.
- Latency, contiguous valid: start accepted at cycle 0 gives LOAD at cycles 1..N, DRAIN at N+1..3N-2, and o_done at cycle 3N-1.
- o_c is driven directly from the PE accumulators. It is valid when o_done=1 and stays stable until the next accepted i_start. Consumers must not sample it during LOAD or DRAIN.

Test Plan:
- Identity: N=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=I, contiguous valid, start at cycle 0. Required: o_done exactly at cycle 8, C=A, o_c stable until next start.
- Max values: all A,B=255, N=3. Required: every C[i][j]=195075 (ACC_WIDTH=19), no wrap.
- Valid gaps: same A, B=[[9,8,7],[6,5,4],[3,2,1]], i_valid low for 2 cycles between beats 1 and 2. Required: C=[[30,24,18],[84,69,54],[138,114,90]], and o_done is delayed by exactly 2 cycles (cycle 10).
- Control: i_start pulsed during LOAD and DRAIN is ignored (result unchanged, no extra o_done). i_valid high in IDLE/DRAIN is not accepted (o_ready=0).
- Reset mid-LOAD: i_rst low after beat 1. Required: all outputs 0 immediately, no o_done. A fresh identity run then gives correct C=A.
- Back-to-back with N=1 and N=4 builds:
  - N=1, A=[[7]], B=[[6]]: C=42, o_done at cycle 2.
  - N=4, random operands: outputs match the reference model.
  - Second run clears the first result.
